sprite_compositor: RTL and testbench

- Parametrised successor to the fixed three-monster pixel mixer.
- Composites N_SPR square sprites over the map/dot background for each VGA pixel. Sprite 0 is the player; sprites 1..N_SPR-1 are enemies.
- Performs per-frame player/enemy collision detection and runs a game-over state machine: PLAY, FLASH (blinking walls), OVER.
- Sits between the map/dot ROMs, the sprite movers and the VGA output register.

---
 rtl/sprite_compositor_pkg.sv | 30 +++
 rtl/sprite_compositor_hit_test.sv | 39 +++
 rtl/sprite_compositor.sv | 221 ++++++++++++++++++++++
 tb/tb_sprite_compositor.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sprite_compositor_pkg.sv
// Shared definitions for the sprite compositor.
// Holds the game state encoding, output colour constants, map ROM class codes
// and a helper for the per-axis collision distance.
package sprite_compositor_pkg;

  typedef enum logic [1:0] {
    ST_PLAY  = 2'b00,
    ST_FLASH = 2'b01,
    ST_OVER  = 2'b10
  } state_t;

  localparam logic [7:0] COLOR_BG        = 8'h00;
  localparam logic [7:0] COLOR_WALL      = 8'hD0;
  localparam logic [7:0] COLOR_WALL_OVER = 8'hFF;
  localparam logic [7:0] COLOR_DOT       = 8'hFF;

  localparam logic [1:0] MAP_WALL  = 2'b00;
  localparam logic [1:0] MAP_FLOOR = 2'b01;

  // |a - b| for two map-relative coordinates; the difference is taken
  // signed at 10 bits so the full 9-bit range cannot wrap.
  function automatic logic [9:0] abs_diff9(input logic [8:0] a, input logic [8:0] b);
    logic signed [9:0] d;
    logic        [9:0] u;
    d = $signed({1'b0, a}) - $signed({1'b0, b});
    u = $unsigned(d);
    return d[9] ? (~u + 10'd1) : u;
  endfunction

endpackage

// File: rtl/sprite_compositor_hit_test.sv
// sprite_hit_test: combinational "does this screen pixel fall inside the
// sprite square" test.
// Ports:
//   x, y   : screen pixel coordinate (11 bits)
//   cx, cy : sprite centre, map-relative (9 bits)
//   en     : sprite enable
//   hit    : pixel lies in [centre-HALF, centre+HALF) on both axes
module sprite_hit_test #(
  parameter int HALF  = 12,
  parameter int ORG_X = 150,
  parameter int ORG_Y = 50
) (
  input  logic [10:0] x,
  input  logic [10:0] y,
  input  logic [8:0]  cx,
  input  logic [8:0]  cy,
  input  logic        en,
  output logic        hit
);

  logic [11:0] x_ext;
  logic [11:0] y_ext;
  logic [11:0] cx_scr;
  logic [11:0] cy_scr;
  logic        hit_x;
  logic        hit_y;

  // HALF is added on the pixel side of the lower bound so no term can go
  // negative near the screen origin.
  assign x_ext  = {1'b0, x};
  assign y_ext  = {1'b0, y};
  assign cx_scr = 12'(ORG_X) + {3'b000, cx};
  assign cy_scr = 12'(ORG_Y) + {3'b000, cy};

  assign hit_x = (x_ext + 12'(HALF) >= cx_scr) && (x_ext < cx_scr + 12'(HALF));
  assign hit_y = (y_ext + 12'(HALF) >= cy_scr) && (y_ext < cy_scr + 12'(HALF));
  assign hit   = en && hit_x && hit_y;

endmodule

// File: rtl/sprite_compositor.sv
// sprite_compositor: composites N_SPR sprites over the map/dot background,
// detects player/enemy collisions once per frame and runs the game-over FSM.
// Ports:
//   clk, reset            : pixel clock, async active-high reset
//   x, y, pix_valid       : screen pixel being drawn
//   spr_x, spr_y          : packed 9-bit sprite centres (map-relative), sprite 0 = player
//   spr_en, spr_color     : per-sprite enable and RGB332 colour
//   map_pixel, dot_pixel  : background classes for the current pixel
//   frame_tick            : one-cycle pulse at frame start
//   clear_over            : restart request (honoured only in OVER)
//   rgb, rgb_valid        : composited colour, 2-cycle latency
//   collide               : sticky per-enemy collision flags (bit 0 unused, 0)
//   game_over, state      : FSM status
//
// state | meaning
// PLAY  | normal play, enemies drawn, collisions evaluated on frame_tick
// FLASH | player hit, walls blink, counts FLASH_FRAMES frame_ticks
// OVER  | walls solid white, waits for clear_over
module sprite_compositor
  import sprite_compositor_pkg::*;
#(
  parameter int N_SPR        = 4,
  parameter int SPR_W        = 24,
  parameter int ORG_X        = 150,
  parameter int ORG_Y        = 50,
  parameter int MAP_W        = 348,
  parameter int MAP_H        = 408,
  parameter int COL_DIST     = 12,
  parameter int FLASH_FRAMES = 64,
  parameter int BLINK_LOG2   = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [10:0]          x,
  input  logic [10:0]          y,
  input  logic                 pix_valid,
  input  logic [9*N_SPR-1:0]   spr_x,
  input  logic [9*N_SPR-1:0]   spr_y,
  input  logic [N_SPR-1:0]     spr_en,
  input  logic [8*N_SPR-1:0]   spr_color,
  input  logic [1:0]           map_pixel,
  input  logic                 dot_pixel,
  input  logic                 frame_tick,
  input  logic                 clear_over,
  output logic [7:0]           rgb,
  output logic                 rgb_valid,
  output logic [N_SPR-1:0]     collide,
  output logic                 game_over,
  output logic [1:0]           state
);

  localparam int HALF  = SPR_W / 2;
  // Counter must be wide enough both to reach FLASH_FRAMES-1 and to own the blink bit.
  localparam int CNT_W = ($clog2(FLASH_FRAMES) > BLINK_LOG2) ? $clog2(FLASH_FRAMES) : BLINK_LOG2 + 1;

  // ---------------- stage 1: geometry ----------------
  logic [N_SPR-1:0] hit_d, hit_q;
  logic             in_map_d, in_map_q;
  logic [1:0]       map_d, map_q;
  logic             dot_d, dot_q;
  logic             v1_d, v1_q;
  logic [11:0]      x_ext, y_ext;

  for (genvar g = 0; g < N_SPR; g++) begin : g_hit
    sprite_hit_test #(
      .HALF (HALF),
      .ORG_X(ORG_X),
      .ORG_Y(ORG_Y)
    ) u_hit (
      .x  (x),
      .y  (y),
      .cx (spr_x[9*g +: 9]),
      .cy (spr_y[9*g +: 9]),
      .en (spr_en[g]),
      .hit(hit_d[g])
    );
  end

  assign x_ext = {1'b0, x};
  assign y_ext = {1'b0, y};

  always_comb begin
    in_map_d = (x_ext >= 12'(ORG_X)) && (x_ext < 12'(ORG_X + MAP_W)) &&
               (y_ext >= 12'(ORG_Y)) && (y_ext < 12'(ORG_Y + MAP_H));
    map_d    = map_pixel;
    dot_d    = dot_pixel;
    v1_d     = pix_valid;
  end

  // ---------------- FSM / collision ----------------
  state_t           state_d, state_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic [N_SPR-1:0] collide_d, collide_q;
  logic             game_over_d, game_over_q;
  logic [N_SPR-1:0] new_hits;

  always_comb begin
    new_hits = '0;
    for (int i = 1; i < N_SPR; i++) begin
      if (spr_en[0] && spr_en[i] &&
          (abs_diff9(spr_x[8:0], spr_x[9*i +: 9]) < 10'(COL_DIST)) &&
          (abs_diff9(spr_y[8:0], spr_y[9*i +: 9]) < 10'(COL_DIST))) begin
        new_hits[i] = 1'b1;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    collide_d = collide_q;
    case (state_q)
      ST_PLAY: begin
        // clear_over is ignored here, so a same-cycle collision always wins.
        if (frame_tick && (new_hits != '0)) begin
          collide_d = collide_q | new_hits;
          state_d   = ST_FLASH;
          cnt_d     = '0;
        end
      end
      ST_FLASH: begin
        if (frame_tick) begin
          if (cnt_q == CNT_W'(FLASH_FRAMES - 1)) begin
            state_d = ST_OVER;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      ST_OVER: begin
        if (clear_over) begin
          state_d   = ST_PLAY;
          collide_d = '0;
          cnt_d     = '0;
        end
      end
      default: begin
        state_d = ST_PLAY;
      end
    endcase
    game_over_d = (state_d != ST_PLAY);
  end

  // ---------------- stage 2: priority colour select ----------------
  logic [7:0] rgb_d, rgb_q;
  logic       v2_d, v2_q;
  logic       enemy_found;
  logic [7:0] enemy_color;
  logic [7:0] wall_color;
  logic [7:0] pix_color;

  always_comb begin
    enemy_found = 1'b0;
    enemy_color = COLOR_BG;
    // Scan downwards so the lowest-index enemy is the one left standing.
    for (int i = N_SPR - 1; i >= 1; i--) begin
      if (hit_q[i]) begin
        enemy_found = 1'b1;
        enemy_color = spr_color[8*i +: 8];
      end
    end

    case (state_q)
      ST_PLAY:  wall_color = COLOR_WALL;
      ST_FLASH: wall_color = cnt_q[BLINK_LOG2] ? COLOR_WALL_OVER : COLOR_WALL;
      default:  wall_color = COLOR_WALL_OVER;
    endcase

    pix_color = COLOR_BG;
    if (!in_map_q) begin
      pix_color = COLOR_BG;
    end else if (hit_q[0]) begin
      pix_color = spr_color[7:0];
    end else if (enemy_found && (state_q == ST_PLAY)) begin
      pix_color = enemy_color;
    end else if (map_q == MAP_WALL) begin
      pix_color = wall_color;
    end else if ((map_q == MAP_FLOOR) && dot_q) begin
      pix_color = COLOR_DOT;
    end

    rgb_d = v1_q ? pix_color : rgb_q;
    v2_d  = v1_q;
  end

  // ---------------- registers ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hit_q       <= '0;
      in_map_q    <= 1'b0;
      map_q       <= 2'b00;
      dot_q       <= 1'b0;
      v1_q        <= 1'b0;
      rgb_q       <= 8'h00;
      v2_q        <= 1'b0;
      state_q     <= ST_PLAY;
      cnt_q       <= '0;
      collide_q   <= '0;
      game_over_q <= 1'b0;
    end else begin
      hit_q       <= hit_d;
      in_map_q    <= in_map_d;
      map_q       <= map_d;
      dot_q       <= dot_d;
      v1_q        <= v1_d;
      rgb_q       <= rgb_d;
      v2_q        <= v2_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      collide_q   <= collide_d;
      game_over_q <= game_over_d;
    end
  end

  assign rgb       = rgb_q;
  assign rgb_valid = v2_q;
  assign collide   = collide_q;
  assign game_over = game_over_q;
  assign state     = state_q;

endmodule

// File: tb/tb_sprite_compositor.sv
module tb_sprite_compositor;
  localparam int N       = 4;
  localparam int HALF    = 12;
  localparam int ORG_X   = 150;
  localparam int ORG_Y   = 50;
  localparam int MAP_W   = 348;
  localparam int MAP_H   = 408;
  localparam int COL     = 12;
  localparam int FFRAMES = 64;
  localparam int BLINK   = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic [10:0]   x, y;
  logic          pix_valid;
  logic [9*N-1:0] spr_x, spr_y;
  logic [N-1:0]  spr_en;
  logic [8*N-1:0] spr_color;
  logic [1:0]    map_pixel;
  logic          dot_pixel, frame_tick, clear_over;
  logic [7:0]    rgb;
  logic          rgb_valid;
  logic [N-1:0]  collide;
  logic          game_over;
  logic [1:0]    state;

  sprite_compositor dut (
    .clk(clk), .reset(reset), .x(x), .y(y), .pix_valid(pix_valid),
    .spr_x(spr_x), .spr_y(spr_y), .spr_en(spr_en), .spr_color(spr_color),
    .map_pixel(map_pixel), .dot_pixel(dot_pixel), .frame_tick(frame_tick),
    .clear_over(clear_over), .rgb(rgb), .rgb_valid(rgb_valid), .collide(collide),
    .game_over(game_over), .state(state)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // ---------------- behavioural model ----------------
  int       m_state;   // 0 play, 1 flash, 2 over
  int       m_cnt;     // frame_ticks seen since entering flash
  logic [N-1:0] m_col;
  logic [7:0] m_rgb;
  bit       m_v2;
  bit       p_v, p_dot;
  int       p_x, p_y, p_map;
  int       p_sx[N], p_sy[N];
  bit       p_en[N];

  task automatic chk(string nm, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_cnt = 0; m_col = '0; m_rgb = 8'h00; m_v2 = 0;
    p_v = 0; p_dot = 0; p_x = 0; p_y = 0; p_map = 0;
    for (int i = 0; i < N; i++) begin p_sx[i] = 0; p_sy[i] = 0; p_en[i] = 0; end
  endtask

  function automatic bit covers(int i);
    return p_en[i] &&
           p_x >= ORG_X + p_sx[i] - HALF && p_x < ORG_X + p_sx[i] + HALF &&
           p_y >= ORG_Y + p_sy[i] - HALF && p_y < ORG_Y + p_sy[i] + HALF;
  endfunction

  function automatic logic [7:0] exp_colour();
    if (!(p_x >= ORG_X && p_x < ORG_X + MAP_W && p_y >= ORG_Y && p_y < ORG_Y + MAP_H))
      return 8'h00;
    if (covers(0)) return spr_color[7:0];
    if (m_state == 0)
      for (int i = 1; i < N; i++)
        if (covers(i)) return spr_color[8*i +: 8];
    if (p_map == 0) begin
      if (m_state == 0) return 8'hD0;
      if (m_state == 2) return 8'hFF;
      return (((m_cnt / (1 << BLINK)) % 2) == 1) ? 8'hFF : 8'hD0;
    end
    if (p_map == 1 && p_dot) return 8'hFF;
    return 8'h00;
  endfunction

  function automatic int iabs(int v);
    return (v < 0) ? -v : v;
  endfunction

  task automatic model_edge();
    int hits;
    m_v2 = p_v;
    if (p_v) m_rgb = exp_colour();
    p_v = pix_valid; p_x = int'(x); p_y = int'(y); p_map = int'(map_pixel); p_dot = dot_pixel;
    for (int i = 0; i < N; i++) begin
      p_sx[i] = int'(spr_x[9*i +: 9]); p_sy[i] = int'(spr_y[9*i +: 9]); p_en[i] = spr_en[i];
    end
    if (m_state == 0) begin
      if (frame_tick && spr_en[0]) begin
        hits = 0;
        for (int i = 1; i < N; i++) begin
          if (spr_en[i] &&
              iabs(int'(spr_x[8:0]) - int'(spr_x[9*i +: 9])) < COL &&
              iabs(int'(spr_y[8:0]) - int'(spr_y[9*i +: 9])) < COL) begin
            m_col[i] = 1'b1;
            hits++;
          end
        end
        if (hits > 0) begin m_state = 1; m_cnt = 0; end
      end
    end else if (m_state == 1) begin
      if (frame_tick) begin
        if (m_cnt == FFRAMES - 1) m_state = 2;
        else m_cnt++;
      end
    end else if (clear_over) begin
      m_state = 0; m_col = '0; m_cnt = 0;
    end
  endtask

  task automatic compare();
    chk("rgb", int'(rgb), int'(m_rgb));
    chk("rgb_valid", int'(rgb_valid), int'(m_v2));
    chk("state", int'(state), m_state);
    chk("collide", int'(collide), int'(m_col));
    chk("game_over", int'(game_over), (m_state != 0) ? 1 : 0);
  endtask

  task automatic cycle();
    @(posedge clk);
    if (reset) model_reset();
    else model_edge();
    @(negedge clk);
    compare();
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic set_spr(int i, int sx, int sy, bit en, logic [7:0] c);
    spr_x[9*i +: 9] = 9'(sx);
    spr_y[9*i +: 9] = 9'(sy);
    spr_en[i] = en;
    spr_color[8*i +: 8] = c;
  endtask

  task automatic pix(string nm, int px, int py, logic [1:0] mp, bit dt, int exp);
    x = 11'(px); y = 11'(py); map_pixel = mp; dot_pixel = dt; pix_valid = 1'b1;
    cycle();
    pix_valid = 1'b0;
    cycle();
    chk(nm, int'(rgb), exp);
  endtask

  task automatic tick(bit clr);
    frame_tick = 1'b1; clear_over = clr;
    cycle();
    frame_tick = 1'b0; clear_over = 1'b0;
  endtask

  initial begin
    reset = 1'b1; x = '0; y = '0; pix_valid = 1'b0; spr_x = '0; spr_y = '0;
    spr_en = '0; spr_color = '0; map_pixel = 2'b01; dot_pixel = 1'b0;
    frame_tick = 1'b0; clear_over = 1'b0;
    model_reset();
    cycle(); cycle();
    chk("reset_state", int'(state), 0);
    reset = 1'b0;
    cycle();

    // single enemy, edges on both axes
    set_spr(0, 300, 300, 1, 8'hE0);
    set_spr(1, 100, 100, 1, 8'h38);
    set_spr(2, 0, 0, 0, 8'h07);
    set_spr(3, 0, 0, 0, 8'h1C);
    pix("x_lo_in",  238, 150, 2'b01, 1, 8'h38);
    pix("x_hi_in",  261, 150, 2'b01, 1, 8'h38);
    pix("x_lo_out", 237, 150, 2'b01, 1, 8'hFF);
    pix("x_hi_out", 262, 150, 2'b01, 1, 8'hFF);
    pix("y_lo_in",  250, 138, 2'b01, 1, 8'h38);
    pix("y_hi_in",  250, 161, 2'b01, 1, 8'h38);
    pix("y_lo_out", 250, 137, 2'b01, 1, 8'hFF);
    pix("y_hi_out", 250, 162, 2'b01, 1, 8'hFF);

    // overlapping sprites: lowest enemy, then player on top
    set_spr(1, 100, 150, 1, 8'h38);
    set_spr(2, 105, 150, 1, 8'h07);
    pix("enemy_prio", 250, 200, 2'b01, 0, 8'h38);
    set_spr(0, 100, 150, 1, 8'hE0);
    pix("player_prio", 250, 200, 2'b01, 0, 8'hE0);

    // collision threshold
    set_spr(0, 50, 50, 1, 8'hE0);
    set_spr(1, 200, 200, 1, 8'h38);
    set_spr(2, 62, 50, 1, 8'h07);
    set_spr(3, 200, 200, 1, 8'h1C);
    tick(0);
    chk("no_collide", int'(collide), 0);
    chk("no_collide_state", int'(state), 0);
    set_spr(2, 61, 40, 1, 8'h07);
    tick(0);
    chk("collide", int'(collide), 4'b0100);
    chk("flash_state", int'(state), 1);

    // flash blinking and transition to over
    for (int t = 0; t < FFRAMES; t++) begin
      pix("blink_wall", 160, 60, 2'b00, 0, ((t / 8) % 2 == 1) ? 8'hFF : 8'hD0);
      tick(0);
    end
    chk("over_state", int'(state), 2);
    chk("over_game_over", int'(game_over), 1);
    pix("over_wall", 160, 60, 2'b00, 0, 8'hFF);
    pix("over_enemy_hidden", 220, 80, 2'b00, 0, 8'hFF);
    pix("over_player", 200, 100, 2'b01, 0, 8'hE0);

    // restart wins over a same-cycle frame_tick
    tick(1);
    chk("restart_state", int'(state), 0);
    chk("restart_collide", int'(collide), 0);
    pix("left_out", 149, 100, 2'b01, 1, 8'h00);
    pix("left_in",  150, 100, 2'b01, 1, 8'hFF);

    pix_valid = 1'b1; cycle();
    pix_valid = 1'b0; cycle(); chk("rv_toggle_1", int'(rgb_valid), 1);
    pix_valid = 1'b1; cycle(); chk("rv_toggle_0", int'(rgb_valid), 0);
    pix_valid = 1'b0; cycle(); chk("rv_toggle_1b", int'(rgb_valid), 1);

    // randomized traffic against the model
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(1, 0) == 1) begin
        x = 11'($urandom_range(260, 170)); y = 11'($urandom_range(150, 60));
      end else begin
        x = 11'($urandom_range(520, 130)); y = 11'($urandom_range(480, 30));
      end
      pix_valid = ($urandom_range(3, 0) != 0);
      for (int i = 0; i < N; i++)
        set_spr(i, $urandom_range(90, 30), $urandom_range(90, 30),
                ($urandom_range(7, 0) != 0), 8'($urandom));
      map_pixel  = 2'($urandom);
      dot_pixel  = 1'($urandom);
      frame_tick = ($urandom_range(3, 0) == 0);
      clear_over = ($urandom_range(9, 0) == 0);
      reset      = ($urandom_range(499, 0) == 0);
      cycle();
    end
    reset = 1'b0; frame_tick = 1'b0; clear_over = 1'b0;

    // reset in the middle of a pixel stream
    pix_valid = 1'b1;
    cycle(); cycle();
    reset = 1'b1;
    #1;
    chk("async_rgb", int'(rgb), 0);
    chk("async_rv", int'(rgb_valid), 0);
    chk("async_state", int'(state), 0);
    chk("async_collide", int'(collide), 0);
    cycle();
    reset = 1'b0;
    cycle(); chk("resume_rv0", int'(rgb_valid), 0);
    cycle(); chk("resume_rv1", int'(rgb_valid), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
